carrd_vrf_writer: RTL

CARRD_VRF_WRITER -- requirements
Module: carrd_vrf_writer

---
 rtl/carrd_pkg.sv | 26 ++
 rtl/carrd_wb_fifo.sv | 60 ++++++
 rtl/carrd_vrf_writer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/carrd_pkg.sv
// Shared types and constants for the CARRD writeback path (carrd_vrf_writer, carrd_wb_fifo).
package carrd_pkg;

  localparam int CARRD_BEATS      = 4;
  localparam int CARRD_BEAT_W     = 128;
  localparam int CARRD_REG_ADDR_W = 5;
  localparam int CARRD_DATA_W     = CARRD_BEATS * CARRD_BEAT_W;

  typedef struct packed {
    logic                        v_en;
    logic                        x_en;
    logic [CARRD_REG_ADDR_W-1:0] dest;
    logic [CARRD_DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic {
    IDLE,
    BEAT
  } wb_state_t;

  function automatic logic [CARRD_BEAT_W-1:0] beat_slice(input logic [CARRD_DATA_W-1:0] data,
                                                         input logic [1:0]              beat);
    return data[beat*CARRD_BEAT_W +: CARRD_BEAT_W];
  endfunction

endpackage

// File: rtl/carrd_wb_fifo.sv
// Synchronous FIFO of writeback entries; when empty, a same-cycle push falls through to head
// so the writer can start a sequence on the cycle after acceptance.
module carrd_wb_fifo
  import carrd_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t head,
  output logic      avail,
  output logic      full,
  output logic      empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [FIFO_DEPTH];
  wb_entry_t   mem_d [FIFO_DEPTH];
  logic        do_push, do_pop;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    avail = !empty || push;
    head  = empty ? din : mem_q[rd_ptr_q[AW-1:0]];
  end

  // A push and pop into an empty FIFO is a pure pass-through: no storage, no pointer motion.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && !full && !(empty && pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/carrd_vrf_writer.sv
// Serialises buffered 512-bit writeback entries into 4 x 128-bit VRF beats plus an XRF write.
// Optional CARRD_WB_BYPASS_EN: idle/empty entries issue beat 0 in the push cycle.
module carrd_vrf_writer
  import carrd_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_v_wr_en,
  input  logic         wb_x_wr_en,
  input  logic [4:0]   wb_dest,
  input  logic [127:0] wb_data_1,
  input  logic [127:0] wb_data_2,
  input  logic [127:0] wb_data_3,
  input  logic [127:0] wb_data_4,
  output logic         wb_ready,
  output logic         vrf_wr_en,
  output logic [4:0]   vrf_wr_addr,
  output logic [1:0]   vrf_wr_beat,
  output logic [127:0] vrf_wr_data,
  output logic         xrf_wr_en,
  output logic [4:0]   xrf_wr_addr,
  output logic [31:0]  xrf_wr_data,
  output logic         busy
);

  wb_entry_t in_entry, head, cur_q, cur_d;
  wb_state_t state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic fifo_full, fifo_empty, fifo_avail, fifo_push, fifo_pop;
  logic accept, bypass_hit, last_beat;

  always_comb begin
    in_entry.v_en = wb_v_wr_en;
    in_entry.x_en = wb_x_wr_en;
    in_entry.dest = wb_dest;
    in_entry.data = {wb_data_4, wb_data_3, wb_data_2, wb_data_1};
  end

  assign wb_ready = !fifo_full;
  assign accept   = (wb_v_wr_en || wb_x_wr_en) && wb_ready;

`ifdef CARRD_WB_BYPASS_EN
  assign bypass_hit = accept && (state_q == IDLE) && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign fifo_push = accept && !bypass_hit;
  assign last_beat = !cur_q.v_en || (beat_q == 2'(CARRD_BEATS - 1));
  assign busy      = !fifo_empty || (state_q == BEAT);

  carrd_wb_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (in_entry),
    .pop  (fifo_pop),
    .head (head),
    .avail(fifo_avail),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_q <= cur_d;
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    cur_d    = cur_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (bypass_hit) begin
          // Beat 0 already went out this cycle; x-only entries are finished.
          if (in_entry.v_en) begin
            state_d = BEAT;
            beat_d  = 2'd1;
            cur_d   = in_entry;
          end
        end else if (fifo_avail) begin
          state_d  = BEAT;
          beat_d   = 2'd0;
          cur_d    = head;
          fifo_pop = 1'b1;
        end
      end
      BEAT: begin
        if (!last_beat) begin
          beat_d = beat_q + 2'd1;
        end else if (fifo_avail) begin
          beat_d   = 2'd0;
          cur_d    = head;
          fifo_pop = 1'b1;
        end else begin
          state_d = IDLE;
          beat_d  = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = 2'd0;
      end
    endcase
  end

  always_comb begin
    vrf_wr_en   = 1'b0;
    vrf_wr_addr = '0;
    vrf_wr_beat = '0;
    vrf_wr_data = '0;
    xrf_wr_en   = 1'b0;
    xrf_wr_addr = '0;
    xrf_wr_data = '0;
    if (state_q == BEAT) begin
      vrf_wr_en   = cur_q.v_en;
      vrf_wr_addr = cur_q.dest;
      vrf_wr_beat = beat_q;
      vrf_wr_data = beat_slice(cur_q.data, beat_q);
      xrf_wr_en   = cur_q.x_en && (beat_q == 2'd0);
      xrf_wr_addr = cur_q.dest;
      xrf_wr_data = cur_q.data[31:0];
    end else if (bypass_hit) begin
      vrf_wr_en   = in_entry.v_en;
      vrf_wr_addr = in_entry.dest;
      vrf_wr_data = beat_slice(in_entry.data, 2'd0);
      xrf_wr_en   = in_entry.x_en;
      xrf_wr_addr = in_entry.dest;
      xrf_wr_data = in_entry.data[31:0];
    end
  end

endmodule
